// File: rtl/prog_loader.sv
// prog_loader: boot-time program loader for the 8-bit CPU.
// Accepts a stream of the form length byte, payload bytes, checksum byte over a
// valid/ready handshake and writes the payload into program RAM. The CPU is held
// off the RAM port while a load runs. A good checksum releases the CPU and
// pulses cpu_run. A bad checksum or an abort raises err.
module prog_loader #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] ld_addr,
    output logic [DATA_W-1:0] ld_data,
    output logic              ld_wren,
    output logic              cpu_hold,
    output logic              cpu_run,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_RUN  = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] BASE_C   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1'b1);
    localparam logic [DATA_W-1:0] DATA_ONE = DATA_W'(1'b1);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   rem_q, rem_d;      // payload bytes still expected
    logic [ADDR_W-1:0]   wa_q, wa_d;        // address of the next payload byte
    logic [DATA_W-1:0]   sum_q, sum_d;      // running payload sum
    logic [ADDR_W-1:0]   ld_addr_q, ld_addr_d;
    logic [DATA_W-1:0]   ld_data_q, ld_data_d;
    logic                wren_q, wren_d;
    logic                hold_q, hold_d;
    logic                run_q, run_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                xfer_s;
    logic [DATA_W-1:0]   sum_in_s;

    assign xfer_s   = in_valid && busy_q;
    assign sum_in_s = sum_q + in_data;

    // Next-state and next-output decode for the load sequence
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        wa_d      = wa_q;
        sum_d     = sum_q;
        ld_addr_d = ld_addr_q;
        ld_data_d = ld_data_q;
        wren_d    = 1'b0;
        run_d     = 1'b0;
        done_d    = done_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    sum_d   = '0;
                end else begin
                    state_d = state_q;
                end
            end
            S_LEN: begin
                if (xfer_s) begin
                    // A length of zero is taken as 2**DATA_W bytes: the counter
                    // wraps through all values before it reaches one.
                    rem_d   = in_data;
                    wa_d    = BASE_C;
                    state_d = S_DATA;
                end else begin
                    state_d = S_LEN;
                end
            end
            S_DATA: begin
                if (xfer_s) begin
                    wren_d    = 1'b1;
                    ld_addr_d = wa_q;
                    ld_data_d = in_data;
                    wa_d      = wa_q + ADDR_ONE;
                    sum_d     = sum_in_s;
                    if (rem_q == DATA_ONE) begin
                        state_d = S_CSUM;
                    end else begin
                        rem_d = rem_q - DATA_ONE;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_CSUM: begin
                if (xfer_s) begin
                    if (sum_in_s == '0) begin
                        state_d = S_RUN;
                        run_d   = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end else begin
                    state_d = S_CSUM;
                end
            end
            S_RUN: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Abort overrides everything while loading; a byte already taken on
        // this cycle still gets written because wren_d is left alone.
        if (abort && busy_q) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            done_d  = 1'b0;
            run_d   = 1'b0;
        end else begin
            state_d = state_d;
        end
        busy_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
        // Keep the RAM port while a write is still being issued.
        hold_d = busy_d || wren_d;
    end

    // State and registered outputs, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            rem_q     <= '0;
            wa_q      <= '0;
            sum_q     <= '0;
            ld_addr_q <= '0;
            ld_data_q <= '0;
            wren_q    <= 1'b0;
            hold_q    <= 1'b0;
            run_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            wa_q      <= wa_d;
            sum_q     <= sum_d;
            ld_addr_q <= ld_addr_d;
            ld_data_q <= ld_data_d;
            wren_q    <= wren_d;
            hold_q    <= hold_d;
            run_q     <= run_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign in_ready = busy_q;
    assign busy     = busy_q;
    assign ld_addr  = ld_addr_q;
    assign ld_data  = ld_data_q;
    assign ld_wren  = wren_q;
    assign cpu_hold = hold_q;
    assign cpu_run  = run_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
